// File: rtl/hd63701_irq_sched_if.sv
// Core-side interrupt handshake: scheduler presents req/vec/src/wake, core returns a one-clock ack
// when it begins fetching the presented vector.
interface hd63701_irq_sched_if;
  logic        int_req;
  logic [15:0] int_vec;
  logic [2:0]  int_src;
  logic        wake;
  logic        int_ack;

  modport master (
    output int_req,
    output int_vec,
    output int_src,
    output wake,
    input  int_ack
  );

  modport slave (
    input  int_req,
    input  int_vec,
    input  int_src,
    input  wake,
    output int_ack
  );
endinterface

// File: rtl/hd63701_irq_sched.sv
// HD63701 interrupt scheduler: fixed-priority pick with I-mask, one frozen vector held until the core
// acks; 1 clk for internal sources, SYNC_STAGES+1 (IRQ1) / +2 (NMI) from the pins.
module hd63701_irq_sched #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                mcu_clx2,
  input  logic                mcu_rst_n,
  input  logic                nmi_in,
  input  logic                irq1_in,
  input  logic                ici_in,
  input  logic                oci_in,
  input  logic                toi_in,
  input  logic                sci_in,
  input  logic                i_mask,
  hd63701_irq_sched_if.master core_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_NMI  = 3'd1;
  localparam logic [2:0] SRC_IRQ1 = 3'd2;
  localparam logic [2:0] SRC_ICI  = 3'd3;
  localparam logic [2:0] SRC_OCI  = 3'd4;
  localparam logic [2:0] SRC_TOI  = 3'd5;
  localparam logic [2:0] SRC_SCI  = 3'd6;

  localparam logic [15:0] VEC_RESET = 16'hFFFE;
  localparam logic [15:0] VEC_NMI   = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ1  = 16'hFFF8;
  localparam logic [15:0] VEC_ICI   = 16'hFFF6;
  localparam logic [15:0] VEC_OCI   = 16'hFFF4;
  localparam logic [15:0] VEC_TOI   = 16'hFFF2;
  localparam logic [15:0] VEC_SCI   = 16'hFFF0;

  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq1_sync_q;
  logic                   nmi_hist_q;
  logic                   nmi_pend_q, nmi_pend_d;
  logic [1:0]             state_q, state_d;
  logic                   int_req_q, int_req_d;
  logic [15:0]            int_vec_q, int_vec_d;
  logic [2:0]             int_src_q, int_src_d;
  logic                   wake_q;

  logic                   nmi_synced;
  logic                   irq1_synced;
  logic                   nmi_edge;
  logic                   nmi_clr;
  logic                   maskable_any;
  logic                   cand_vld;
  logic [15:0]            cand_vec;
  logic [2:0]             cand_src;
  logic                   src_active;

  assign nmi_synced   = nmi_sync_q[SYNC_STAGES-1];
  assign irq1_synced  = irq1_sync_q[SYNC_STAGES-1];
  assign nmi_edge     = nmi_synced & ~nmi_hist_q;
  assign maskable_any = irq1_synced | ici_in | oci_in | toi_in | sci_in;

  // A pending NMI beats everything; maskable sources only compete while the I flag is clear.
  always_comb begin
    cand_vld = 1'b0;
    cand_vec = VEC_RESET;
    cand_src = SRC_NONE;
    if (nmi_pend_q) begin
      cand_vld = 1'b1;
      cand_vec = VEC_NMI;
      cand_src = SRC_NMI;
    end else if (!i_mask) begin
      if (irq1_synced) begin
        cand_vld = 1'b1;
        cand_vec = VEC_IRQ1;
        cand_src = SRC_IRQ1;
      end else if (ici_in) begin
        cand_vld = 1'b1;
        cand_vec = VEC_ICI;
        cand_src = SRC_ICI;
      end else if (oci_in) begin
        cand_vld = 1'b1;
        cand_vec = VEC_OCI;
        cand_src = SRC_OCI;
      end else if (toi_in) begin
        cand_vld = 1'b1;
        cand_vec = VEC_TOI;
        cand_src = SRC_TOI;
      end else if (sci_in) begin
        cand_vld = 1'b1;
        cand_vec = VEC_SCI;
        cand_src = SRC_SCI;
      end
    end
  end

  always_comb begin
    src_active = 1'b0;
    case (int_src_q)
      SRC_IRQ1: src_active = irq1_synced;
      SRC_ICI:  src_active = ici_in;
      SRC_OCI:  src_active = oci_in;
      SRC_TOI:  src_active = toi_in;
      SRC_SCI:  src_active = sci_in;
      default:  src_active = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    int_src_d = int_src_q;
    nmi_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          int_req_d = 1'b1;
          int_vec_d = cand_vec;
          int_src_d = cand_src;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Ack beats withdrawal; an NMI in service is never withdrawn.
        if (core_if.int_ack) begin
          int_req_d = 1'b0;
          int_src_d = SRC_NONE;
          nmi_clr   = (int_src_q == SRC_NMI);
          state_d   = ST_GUARD;
        end else if ((int_src_q != SRC_NMI) && (!src_active || i_mask)) begin
          int_req_d = 1'b0;
          int_src_d = SRC_NONE;
          state_d   = ST_IDLE;
        end
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        int_req_d = 1'b0;
        int_src_d = SRC_NONE;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // A fresh edge in the same cycle as the ack of the previous NMI must not be lost.
  assign nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      nmi_sync_q  <= '1;
      nmi_hist_q  <= 1'b1;
      irq1_sync_q <= '0;
      nmi_pend_q  <= 1'b0;
      state_q     <= ST_IDLE;
      int_req_q   <= 1'b0;
      int_vec_q   <= VEC_RESET;
      int_src_q   <= SRC_NONE;
      wake_q      <= 1'b0;
    end else begin
      nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_in};
      nmi_hist_q  <= nmi_synced;
      irq1_sync_q <= {irq1_sync_q[SYNC_STAGES-2:0], irq1_in};
      nmi_pend_q  <= nmi_pend_d;
      state_q     <= state_d;
      int_req_q   <= int_req_d;
      int_vec_q   <= int_vec_d;
      int_src_q   <= int_src_d;
      wake_q      <= nmi_pend_q | (maskable_any & ~i_mask);
    end
  end

  assign core_if.int_req = int_req_q;
  assign core_if.int_vec = int_vec_q;
  assign core_if.int_src = int_src_q;
  assign core_if.wake    = wake_q;

endmodule

// File: tb/tb_hd63701_irq_sched.sv
// Bench for hd63701_irq_sched: directed scenarios plus random traffic, scored against a delay-line model.
module tb_hd63701_irq_sched;
  localparam int S = 2;

  logic clk;
  logic rst_n;
  logic nmi, irq1, ici, oci, toi, sci, imask, ack;

  int n_checks = 0;
  int n_errors = 0;

  hd63701_irq_sched_if bus ();
  assign bus.int_ack = ack;

  hd63701_irq_sched #(.SYNC_STAGES(S)) dut (
    .mcu_clx2 (clk),
    .mcu_rst_n(rst_n),
    .nmi_in   (nmi),
    .irq1_in  (irq1),
    .ici_in   (ici),
    .oci_in   (oci),
    .toi_in   (toi),
    .sci_in   (sci),
    .i_mask   (imask),
    .core_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pins seen through an S-deep delay line, one request in service at a time.
  bit          m_nmi_dl[$];
  bit          m_irq_dl[$];
  bit          m_pend, m_req, m_guard, m_wake;
  logic [2:0]  m_src;
  logic [15:0] m_vec;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] vec_of(input int s);
    case (s)
      1: return 16'hFFFC;
      2: return 16'hFFF8;
      3: return 16'hFFF6;
      4: return 16'hFFF4;
      5: return 16'hFFF2;
      6: return 16'hFFF0;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nmi_dl.delete();
    m_irq_dl.delete();
    for (int i = 0; i <= S; i++) begin
      m_nmi_dl.push_back(1'b1);
      m_irq_dl.push_back(1'b0);
    end
    m_pend = 0; m_req = 0; m_guard = 0; m_wake = 0;
    m_src = 3'd0; m_vec = 16'hFFFE;
  endtask

  task automatic model_step();
    bit lv [7];
    bit rise, any, clr;
    int pick;
    if (!rst_n) begin
      model_reset();
    end else begin
      lv[0] = 0; lv[1] = 0;
      lv[2] = m_irq_dl[S-1]; lv[3] = ici; lv[4] = oci; lv[5] = toi; lv[6] = sci;
      rise = m_nmi_dl[S-1] & ~m_nmi_dl[S];
      any  = lv[2] | lv[3] | lv[4] | lv[5] | lv[6];
      clr  = 0;
      if (m_guard) begin
        m_guard = 0;
      end else if (m_req) begin
        if (ack) begin
          clr = (m_src == 3'd1);
          m_req = 0; m_src = 3'd0; m_guard = 1;
        end else if (m_src != 3'd1 && (!lv[m_src] || imask)) begin
          m_req = 0; m_src = 3'd0;
        end
      end else begin
        pick = 0;
        if (m_pend) pick = 1;
        else if (!imask)
          for (int s = 2; s <= 6; s++)
            if (lv[s] && pick == 0) pick = s;
        if (pick != 0) begin
          m_req = 1; m_src = 3'(pick); m_vec = vec_of(pick);
        end
      end
      m_wake = m_pend | (any & ~imask);
      m_pend = rise | (m_pend & ~clr);
      m_nmi_dl.push_front(nmi);  void'(m_nmi_dl.pop_back());
      m_irq_dl.push_front(irq1); void'(m_irq_dl.pop_back());
    end
    exp_q.push_back({11'd0, m_req, m_wake, m_src, m_vec});
  endtask

  // Monitor: every observed cycle is scored against the model's record for that edge.
  initial begin
    logic [31:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {11'd0, bus.int_req, bus.wake, bus.int_src, bus.int_vec};
        chk("cycle{req,wake,src,vec}", g, e);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1; nmi = 1; irq1 = 1; ici = 1; oci = 1; toi = 1; sci = 1; imask = 1; ack = 1;
    model_reset();
    #1 rst_n = 0;

    // T1: reset with all inputs high, release with NMI still high
    ticks(3);
    chk("t1_req", bus.int_req, 0);
    chk("t1_vec", bus.int_vec, 16'hFFFE);
    chk("t1_src", bus.int_src, 0);
    chk("t1_wake", bus.wake, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_no_nmi", bus.int_req, 0);
    end
    irq1 = 0; ici = 0; oci = 0; toi = 0; sci = 0; ack = 0;
    ticks(S + 2);

    // T2: OCI latency, ack, guard cycle, re-request
    imask = 0; oci = 1;
    tick();
    chk("t2_req", bus.int_req, 1);
    chk("t2_vec", bus.int_vec, 16'hFFF4);
    chk("t2_src", bus.int_src, 4);
    ticks(2);
    ack = 1; tick(); ack = 0;
    chk("t2_guard_req", bus.int_req, 0);
    chk("t2_guard_vec", bus.int_vec, 16'hFFF4);
    tick();
    chk("t2_idle_req", bus.int_req, 0);
    tick();
    chk("t2_rereq", bus.int_req, 1);
    chk("t2_rereq_src", bus.int_src, 4);
    ack = 1; oci = 0; tick(); ack = 0;
    ticks(2);
    chk("t2_quiet", bus.int_req, 0);

    // T3: IRQ1 outranks SCI, then SCI after the guard
    imask = 1; irq1 = 1;
    ticks(S + 1);
    sci = 1; imask = 0;
    tick();
    chk("t3_irq1_vec", bus.int_vec, 16'hFFF8);
    chk("t3_irq1_src", bus.int_src, 2);
    ack = 1; irq1 = 0; tick(); ack = 0;
    chk("t3_guard", bus.int_req, 0);
    tick();
    chk("t3_idle", bus.int_req, 0);
    tick();
    chk("t3_sci_vec", bus.int_vec, 16'hFFF0);
    chk("t3_sci_src", bus.int_src, 6);
    ack = 1; sci = 0; tick(); ack = 0;
    ticks(2);

    // T4: NMI edge under I-mask, exactly one service
    imask = 1; nmi = 0;
    ticks(S + 2);
    nmi = 1;
    ticks(S + 1);
    chk("t4_early", bus.int_req, 0);
    tick();
    chk("t4_req", bus.int_req, 1);
    chk("t4_vec", bus.int_vec, 16'hFFFC);
    chk("t4_src", bus.int_src, 1);
    chk("t4_wake", bus.wake, 1);
    ack = 1; tick(); ack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_single", bus.int_req, 0);
    end

    // T5: withdrawal on mask, no preemption of SCI by NMI
    imask = 0; toi = 1;
    tick();
    chk("t5_toi_vec", bus.int_vec, 16'hFFF2);
    tick();
    imask = 1; tick();
    chk("t5_withdraw_req", bus.int_req, 0);
    chk("t5_withdraw_src", bus.int_src, 0);
    toi = 0; imask = 0;
    ticks(2);
    sci = 1; tick();
    chk("t5_sci_src", bus.int_src, 6);
    nmi = 0; ticks(S + 2);
    nmi = 1; ticks(S + 2);
    chk("t5_no_preempt", bus.int_src, 6);
    chk("t5_wake", bus.wake, 1);
    ack = 1; sci = 0; tick(); ack = 0;
    tick();
    tick();
    chk("t5_nmi_next_src", bus.int_src, 1);
    chk("t5_nmi_next_vec", bus.int_vec, 16'hFFFC);
    ack = 1; tick(); ack = 0;
    ticks(2);

    // T6: async reset mid-HOLD with NMI pending
    sci = 1; tick();
    nmi = 0; ticks(S + 2);
    nmi = 1; ticks(S + 2);
    chk("t6_hold_src", bus.int_src, 6);
    chk("t6_pend_wake", bus.wake, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_req", bus.int_req, 0);
    chk("t6_rst_vec", bus.int_vec, 16'hFFFE);
    chk("t6_rst_src", bus.int_src, 0);
    chk("t6_rst_wake", bus.wake, 0);
    model_reset();
    ticks(2);
    sci = 0; imask = 1; rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_nmi", bus.int_req, 0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)  nmi   = ~nmi;
      if ($urandom_range(0, 11) == 0) irq1  = ~irq1;
      if ($urandom_range(0, 7) == 0)  ici   = ~ici;
      if ($urandom_range(0, 7) == 0)  oci   = ~oci;
      if ($urandom_range(0, 7) == 0)  toi   = ~toi;
      if ($urandom_range(0, 7) == 0)  sci   = ~sci;
      if ($urandom_range(0, 9) == 0)  imask = ~imask;
      ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end
    ack = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
